// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C request arbiter: FSM encoding, field widths
// and the default per-transaction watchdog limit.
package i2c_arb_pkg;

  localparam int unsigned DEV_W  = 8;
  localparam int unsigned REG_W  = 16;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned DEFAULT_TIMEOUT_CYC = 32'd2_000_000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending requester after the last
// grant, wrapping around; valid is low when nothing is pending.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               valid
);

  int rank;
  int best_rank;

  always_comb begin
    winner    = last;
    valid     = 1'b0;
    best_rank = int'(NUM_REQ);
    rank      = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      // Distance from the slot just after the last grant; smallest wins.
      rank = (i + 2 * int'(NUM_REQ) - int'(last) - 1) % int'(NUM_REQ);
      if (pending[i] && rank < best_rank) begin
        best_rank = rank;
        winner    = 2'(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters, with a
// per-transaction watchdog that aborts a stalled master.
module i2c_req_arbiter import i2c_arb_pkg::*; #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [DEV_W*NUM_REQ-1:0]  req_dev_addr,
  input  logic [REG_W*NUM_REQ-1:0]  req_reg_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      i2c_write_req,
  output logic                      i2c_read_req,
  input  logic                      i2c_write_req_ack,
  input  logic                      i2c_read_req_ack,
  output logic [DEV_W-1:0]          i2c_slave_dev_addr,
  output logic [REG_W-1:0]          i2c_slave_reg_addr,
  output logic [DATA_W-1:0]         i2c_write_data,
  input  logic [DATA_W-1:0]         i2c_read_data,
  input  logic                      i2c_error,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic                      timeout
);

  localparam logic [31:0] WdogLast = 32'(TIMEOUT_CYC - 1);

  arb_state_e          state_q;
  logic [31:0]         wdog_q;
  logic [1:0]          pick_id;
  logic                pick_valid;
  logic                sel_wr;
  logic [DEV_W-1:0]    sel_dev;
  logic [REG_W-1:0]    sel_reg;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic                master_ack;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .pending(req_wr | req_rd),
    .last   (grant_id),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  always_comb begin
    sel_wr       = 1'b0;
    sel_dev      = '0;
    sel_reg      = '0;
    sel_wdata    = '0;
    grant_onehot = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_id == 2'(i)) begin
        sel_wr    = req_wr[i];
        sel_dev   = req_dev_addr[i*DEV_W +: DEV_W];
        sel_reg   = req_reg_addr[i*REG_W +: REG_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
      grant_onehot[i] = (grant_id == 2'(i));
    end
  end

  // Only the ack matching the issued request type completes a transaction.
  assign master_ack = (i2c_write_req & i2c_write_req_ack) | (i2c_read_req & i2c_read_req_ack);
  assign busy       = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= S_IDLE;
      wdog_q             <= '0;
      grant_id           <= 2'(NUM_REQ - 1);
      i2c_write_req      <= 1'b0;
      i2c_read_req       <= 1'b0;
      i2c_slave_dev_addr <= '0;
      i2c_slave_reg_addr <= '0;
      i2c_write_data     <= '0;
      req_ack            <= '0;
      req_err            <= 1'b0;
      req_rdata          <= '0;
      timeout            <= 1'b0;
    end else begin
      req_ack <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            state_q            <= S_BUSY;
            grant_id           <= pick_id;
            wdog_q             <= '0;
            i2c_slave_dev_addr <= sel_dev;
            i2c_slave_reg_addr <= sel_reg;
            i2c_write_data     <= sel_wdata;
            i2c_write_req      <= sel_wr;
            i2c_read_req       <= ~sel_wr;
          end
        end
        S_BUSY: begin
          if (master_ack) begin
            state_q       <= S_DONE;
            i2c_write_req <= 1'b0;
            i2c_read_req  <= 1'b0;
            req_rdata     <= i2c_read_data;
            req_err       <= i2c_error;
            req_ack       <= grant_onehot;
          end else if (wdog_q == WdogLast) begin
            state_q       <= S_DONE;
            i2c_write_req <= 1'b0;
            i2c_read_req  <= 1'b0;
            req_rdata     <= '0;
            req_err       <= 1'b1;
            req_ack       <= grant_onehot;
            timeout       <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized bench for i2c_req_arbiter: behavioural requesters and master, with
// a transaction-level model of round-robin order, latency and status.
module tb_i2c_req_arbiter;

  localparam int N = 3;
  localparam int T = 100;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_wr;
  logic [N-1:0]  req_rd;
  logic [8*N-1:0]  req_dev_addr;
  logic [16*N-1:0] req_reg_addr;
  logic [8*N-1:0]  req_wdata;
  logic [N-1:0]  req_ack;
  logic          req_err;
  logic [7:0]    req_rdata;
  logic          i2c_write_req;
  logic          i2c_read_req;
  logic          i2c_write_req_ack;
  logic          i2c_read_req_ack;
  logic [7:0]    i2c_slave_dev_addr;
  logic [15:0]   i2c_slave_reg_addr;
  logic [7:0]    i2c_write_data;
  logic [7:0]    i2c_read_data;
  logic          i2c_error;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout;

  i2c_req_arbiter #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_wr            (req_wr),
    .req_rd            (req_rd),
    .req_dev_addr      (req_dev_addr),
    .req_reg_addr      (req_reg_addr),
    .req_wdata         (req_wdata),
    .req_ack           (req_ack),
    .req_err           (req_err),
    .req_rdata         (req_rdata),
    .i2c_write_req     (i2c_write_req),
    .i2c_read_req      (i2c_read_req),
    .i2c_write_req_ack (i2c_write_req_ack),
    .i2c_read_req_ack  (i2c_read_req_ack),
    .i2c_slave_dev_addr(i2c_slave_dev_addr),
    .i2c_slave_reg_addr(i2c_slave_reg_addr),
    .i2c_write_data    (i2c_write_data),
    .i2c_read_data     (i2c_read_data),
    .i2c_error         (i2c_error),
    .grant_id          (grant_id),
    .busy              (busy),
    .timeout           (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester state as seen by the model.
  bit          pend_wr [N];
  bit          pend_rd [N];
  logic [7:0]  f_dev   [N];
  logic [15:0] f_reg   [N];
  logic [7:0]  f_wd    [N];

  int last_grant;
  bit tmo_exp;
  int checks;
  int errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < N; i++) begin
      req_wr[i]               = pend_wr[i];
      req_rd[i]               = pend_rd[i];
      req_dev_addr[i*8 +: 8]  = f_dev[i];
      req_reg_addr[i*16 +: 16] = f_reg[i];
      req_wdata[i*8 +: 8]     = f_wd[i];
    end
  endtask

  task automatic raise(input int i, input bit wr, input bit rd,
                       input logic [7:0] dev, input logic [15:0] rg, input logic [7:0] wd);
    pend_wr[i] = wr;
    pend_rd[i] = rd;
    f_dev[i]   = dev;
    f_reg[i]   = rg;
    f_wd[i]    = wd;
    apply_reqs();
  endtask

  function automatic int next_winner();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last_grant + k) % N;
      if (pend_wr[idx] || pend_rd[idx]) return idx;
    end
    return -1;
  endfunction

  // Starts in an idle cycle with requests set up; ends in the following idle cycle.
  // delay 0 means the master never answers and the watchdog must fire.
  task automatic serve(input int delay, input bit noise, input bit fixed, input logic [7:0] fixed_rd);
    int w;
    int limit;
    bit is_wr;
    logic [7:0] exp_rd;
    logic exp_err;
    w = next_winner();
    if (w < 0) return;
    is_wr   = pend_wr[w];
    limit   = (delay == 0) ? T : delay;
    exp_rd  = 8'h00;
    exp_err = 1'b1;
    tick();
    check_eq("grant_id", 32'(grant_id), 32'(w));
    check_eq("busy_on_grant", 32'(busy), 1);
    check_eq("dev_latch", 32'(i2c_slave_dev_addr), 32'(f_dev[w]));
    check_eq("reg_latch", 32'(i2c_slave_reg_addr), 32'(f_reg[w]));
    check_eq("wdata_latch", 32'(i2c_write_data), 32'(f_wd[w]));
    for (int c = 1; c <= limit; c++) begin
      check_eq("mreq_held", 32'({i2c_write_req, i2c_read_req}), is_wr ? 32'd2 : 32'd1);
      check_eq("no_early_ack", 32'(req_ack), 0);
      if (c > 1) check_eq("dev_stable", 32'(i2c_slave_dev_addr), 32'(f_dev[w]));
      i2c_read_data = 8'($urandom);
      i2c_error     = fixed ? 1'b0 : 1'($urandom);
      if (fixed) i2c_read_data = fixed_rd;
      if (c == delay) begin
        if (is_wr) i2c_write_req_ack = 1'b1;
        else i2c_read_req_ack = 1'b1;
        exp_rd  = i2c_read_data;
        exp_err = i2c_error;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        if (is_wr) i2c_read_req_ack = 1'b1;
        else i2c_write_req_ack = 1'b1;
      end
      if (noise) begin
        for (int i = 0; i < N; i++) begin
          if (i != w && !pend_wr[i] && !pend_rd[i]) begin
            f_dev[i] = 8'($urandom);
            f_reg[i] = 16'($urandom);
            f_wd[i]  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
              pend_wr[i] = 1'($urandom);
              pend_rd[i] = !pend_wr[i] || 1'($urandom);
            end
          end
        end
        apply_reqs();
      end
      tick();
      i2c_write_req_ack = 1'b0;
      i2c_read_req_ack  = 1'b0;
    end
    if (delay == 0) tmo_exp = 1'b1;
    check_eq("req_ack", 32'(req_ack), 32'(1) << w);
    check_eq("mreq_low", 32'({i2c_write_req, i2c_read_req}), 0);
    check_eq("req_rdata", 32'(req_rdata), 32'(exp_rd));
    check_eq("req_err", 32'(req_err), 32'(exp_err));
    check_eq("timeout", 32'(timeout), 32'(tmo_exp));
    pend_wr[w] = 1'b0;
    pend_rd[w] = 1'b0;
    apply_reqs();
    last_grant = w;
    tick();
    check_eq("idle_after_ack", 32'(busy), 0);
    check_eq("ack_one_cycle", 32'(req_ack), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_grant"}, 32'(grant_id), 32'(N - 1));
    check_eq({tag, "_mreq"}, 32'({i2c_write_req, i2c_read_req}), 0);
    check_eq({tag, "_ack"}, 32'(req_ack), 0);
    check_eq({tag, "_timeout"}, 32'(timeout), 0);
    check_eq({tag, "_fields"}, 32'({i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data}), 0);
    check_eq({tag, "_status"}, 32'({req_err, req_rdata}), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_state("rst");
    tick();
    rst_n      = 1'b1;
    last_grant = N - 1;
    tmo_exp    = 1'b0;
  endtask

  initial begin
    int d;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    i2c_write_req_ack = 1'b0;
    i2c_read_req_ack  = 1'b0;
    i2c_read_data     = 8'h00;
    i2c_error         = 1'b0;
    for (int i = 0; i < N; i++) raise(i, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
    tick();
    tick();
    check_reset_state("por");
    rst_n      = 1'b1;
    last_grant = N - 1;
    tmo_exp    = 1'b0;
    tick();

    // Single write, master acks after 40 cycles.
    raise(0, 1'b1, 1'b0, 8'h98, 16'h00FF, 8'h5A);
    serve(40, 1'b0, 1'b1, 8'h00);

    // Read from requester 1 returns A7.
    raise(1, 1'b0, 1'b1, 8'h42, 16'h1234, 8'h00);
    serve(15, 1'b0, 1'b1, 8'hA7);

    // Contention from reset: 0, then 1, then 0 again.
    do_reset();
    raise(0, 1'b1, 1'b0, 8'h10, 16'h0010, 8'h01);
    raise(1, 1'b0, 1'b1, 8'h11, 16'h0011, 8'h02);
    serve(3, 1'b0, 1'b0, 8'h00);
    raise(0, 1'b1, 1'b1, 8'h12, 16'h0012, 8'h03);
    serve(2, 1'b0, 1'b0, 8'h00);
    serve(1, 1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stay_idle", 32'(busy), 0);
    end

    // Watchdog abort, then check the flag is sticky across a good transaction.
    raise(2, 1'b1, 1'b0, 8'hC0, 16'hBEEF, 8'h77);
    serve(0, 1'b1, 1'b0, 8'h00);
    raise(2, 1'b0, 1'b1, 8'hC1, 16'hBEF0, 8'h00);
    serve(4, 1'b0, 1'b0, 8'h00);

    // Randomized traffic with stray acks and requests arriving mid-transaction.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_wr[i] && !pend_rd[i] && $urandom_range(0, 1) == 1) begin
          bit wr;
          wr = 1'($urandom);
          raise(i, wr, !wr || 1'($urandom), 8'($urandom), 16'($urandom), 8'($urandom));
        end
      end
      if (next_winner() < 0) raise(n % N, 1'b1, 1'b0, 8'($urandom), 16'($urandom), 8'($urandom));
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      serve(d, 1'b1, 1'b0, 8'h00);
    end

    // Reset during busy cycle 10 aborts without ack.
    for (int i = 0; i < N; i++) raise(i, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
    raise(1, 1'b1, 1'b0, 8'h55, 16'h0A0A, 8'h66);
    for (int c = 1; c <= 10; c++) tick();
    check_eq("pre_reset_busy", 32'(busy), 1);
    do_reset();
    check_eq("no_reissue", 32'({i2c_write_req, i2c_read_req}), 0);
    check_eq("no_ack_after_reset", 32'(req_ack), 0);
    serve(5, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters, legal range 2..4.
REQ-002 Parameter TIMEOUT_CYC, default 32'd2_000_000: clk cycles allowed per transaction before abort.
REQ-003 clk  in  1  single system clock; all logic on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_wr  in  NUM_REQ  per-requester write request, level, held until ack.
REQ-006 req_rd  in  NUM_REQ  per-requester read request, level, held until ack.
REQ-007 req_dev_addr  in  8*NUM_REQ  flattened slave device address, slice i = requester i.
REQ-008 req_reg_addr  in  16*NUM_REQ  flattened register address.
REQ-009 req_wdata  in  8*NUM_REQ  flattened write data.
REQ-010 req_ack  out  NUM_REQ  one-cycle completion pulse to requester i.
REQ-011 req_err  out  1  error status of the transaction being acked; valid with req_ack.
REQ-012 req_rdata  out  8  read data of the transaction being acked; valid with req_ack.
REQ-013 i2c_write_req / i2c_read_req  out  1 each  level requests to i2c_master_top.
REQ-014 i2c_write_req_ack / i2c_read_req_ack  in  1 each  completion from i2c_master_top.
REQ-015 i2c_slave_dev_addr 8, i2c_slave_reg_addr 16, i2c_write_data 8  out  latched transaction fields.
REQ-016 i2c_read_data  in  8; i2c_error  in  1  master results.
REQ-017 grant_id  out  2  index of current/last granted requester; busy  out  1  state != S_IDLE.
REQ-018 timeout  out  1  sticky flag, set on any watchdog abort.

Function
REQ-019 States: S_IDLE, S_BUSY, S_DONE; encoding from shared package.
REQ-020 S_IDLE: requester i pending when req_wr[i] | req_rd[i]; if any pending, go S_BUSY next cycle.
REQ-021 Round-robin selection: search starts at (grant_id+1) mod NUM_REQ, first pending wins; grant_id updated on entry to S_BUSY.
REQ-022 On entry to S_BUSY: latch dev/reg addr and wdata of winner; assert i2c_write_req if req_wr, else i2c_read_req; write has priority when both set.
REQ-023 Master request held high throughout S_BUSY, never both high simultaneously.
REQ-024 S_BUSY exit on matching ack (i2c_write_req_ack for write, i2c_read_req_ack for read): next cycle S_DONE, master request low, req_rdata <= i2c_read_data, req_err <= i2c_error.
REQ-025 Non-matching master ack in S_BUSY ignored.
REQ-026 Watchdog: counter cleared on S_BUSY entry, increments each S_BUSY cycle; at TIMEOUT_CYC-1 without ack go S_DONE with req_err=1, req_rdata=8'h00, timeout<=1.
REQ-027 S_DONE: req_ack[grant_id]=1 for exactly one cycle, then S_IDLE.
REQ-028 Requester drops its req on the edge where req_ack is high; arbiter samples requests only in S_IDLE, so ack-to-next-grant minimum is 2 cycles.
REQ-029 Latency: req in S_IDLE cycle 0 -> master request high cycle 1; master ack cycle k -> req_ack cycle k+1.
REQ-030 Requests changing during S_BUSY/S_DONE ignored; latched fields stable until S_IDLE.
REQ-031 Single pending requester is re-granted every transaction (no starvation, no dead cycles beyond REQ-028).

Reset
REQ-032 rst_n low asynchronously forces: state S_IDLE, i2c_write_req=0, i2c_read_req=0, req_ack=0, req_err=0, req_rdata=0, latched fields=0, grant_id=NUM_REQ-1, watchdog=0, timeout=0.
REQ-033 Reset mid-transaction aborts without ack; no request re-issued after release until sampled in S_IDLE.

Structure
REQ-034 Package i2c_arb_pkg: state encoding, default TIMEOUT_CYC, field widths (8/16/8).
REQ-035 One sub-module rr_pick: combinational round-robin picker (pending vector, last grant -> winner index, valid).

Verification
REQ-036 Single write: req_wr[0], dev 8'h98, reg 16'h00FF, data 8'h5A; master ack after 40 cycles -> i2c_write_req cycles 1..40, req_ack[0] at cycle 41, req_err=0.
REQ-037 Read: req_rd[1], master returns 8'hA7 with ack -> req_rdata=8'hA7 with req_ack[1]; i2c_write_req never high.
REQ-038 Contention: req_wr[0] and req_rd[1] same cycle from reset -> requester 0 served first, then 1, then 0 again when both re-request.
REQ-039 Timeout: TIMEOUT_CYC=100, no master ack -> request drops after 100 busy cycles, req_ack with req_err=1, timeout=1 sticky.
REQ-040 Reset at busy cycle 10 -> master request low immediately, no req_ack; post-reset request served normally.
